// File: rtl/hc4511_pkg.sv
// Shared types and constants for the hc4511 scan controller.
package hc4511_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_LATCH = 2'd2,
      ST_SHOW  = 2'd3
   } scan_state_e;

   // Codes at or above this value are shown blank by the 4511 itself.
   localparam logic [3:0]  BCD_BLANK_MIN = 4'd10;

   localparam int unsigned DEF_SCAN_DIV  = 1000;
   localparam int unsigned DEF_BLANK_CYC = 16;

endpackage

// File: rtl/hc4511_digit_regfile.sv
// Digit register file: one write port, one read port and a per-index
// "this digit and all more significant digits are zero" vector.
module hc4511_digit_regfile #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned IW         = $clog2(NUM_DIGITS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [IW-1:0]         wr_idx,
   input  logic [3:0]            wr_data,
   input  logic [IW-1:0]         rd_idx,
   output logic [3:0]            rd_data,
   output logic [NUM_DIGITS-1:0] zrun
);

   logic [3:0] r_dig [NUM_DIGITS];

   // Out-of-range indices are dropped so non-power-of-two sizes stay safe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NUM_DIGITS); i++) r_dig[i] <= 4'd0;
      end else if (wr_en && (32'(wr_idx) < NUM_DIGITS)) begin
         r_dig[wr_idx] <= wr_data;
      end
   end

   assign rd_data = r_dig[rd_idx];

   always_comb begin
      zrun = '1;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         for (int j = i; j < int'(NUM_DIGITS); j++) begin
            if (r_dig[j] != 4'd0) zrun[i] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/hc4511_scan_ctrl.sv
// Time-multiplexed scan controller for a single hc4511 decoder driving
// NUM_DIGITS common-cathode digits, with guard blanking and leading-zero blanking.
module hc4511_scan_ctrl
   import hc4511_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned SCAN_DIV   = DEF_SCAN_DIV,
   parameter int unsigned BLANK_CYC  = DEF_BLANK_CYC,
   parameter int unsigned IW         = $clog2(NUM_DIGITS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  wr_en,
   input  logic [IW-1:0]         wr_idx,
   input  logic [3:0]            wr_data,
   input  logic                  lz_en,
   input  logic                  lt_req,
   output logic [3:0]            dec_a,
   output logic                  dec_le,
   output logic                  dec_bi_n,
   output logic                  dec_lt_n,
   output logic [NUM_DIGITS-1:0] dig_en,
   output logic [IW-1:0]         cur_idx
);

   localparam int unsigned  SHOW_CYC   = SCAN_DIV - BLANK_CYC - 1;
   localparam int unsigned  CW         = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
   localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYC - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   scan_state_e           r_state;
   logic [CW-1:0]         r_cnt;
   logic [IW-1:0]         r_idx;
   logic                  r_lz_blank;
   logic [3:0]            r_dec_a;
   logic                  r_dec_le;
   logic                  r_dec_bi_n;
   logic                  r_dec_lt_n;
   logic [NUM_DIGITS-1:0] r_dig_en;

   logic [IW-1:0]         w_next_idx;
   logic [IW-1:0]         w_rd_idx;
   logic [3:0]            w_rd_data;
   logic [NUM_DIGITS-1:0] w_zrun;
   logic [NUM_DIGITS-1:0] w_onehot;
   logic                  w_blank_lz;

   assign w_next_idx = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
   // Leaving SHOW loads the next slot's digit, so look ahead one index there.
   assign w_rd_idx   = (r_state == ST_SHOW) ? w_next_idx : r_idx;
   assign w_onehot   = NUM_DIGITS'(1) << r_idx;
   assign w_blank_lz = lz_en && (r_idx != '0) && w_zrun[r_idx];

   hc4511_digit_regfile #(
      .NUM_DIGITS(NUM_DIGITS),
      .IW        (IW)
   ) u_regfile (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (wr_en),
      .wr_idx (wr_idx),
      .wr_data(wr_data),
      .rd_idx (w_rd_idx),
      .rd_data(w_rd_data),
      .zrun   (w_zrun)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_lz_blank <= 1'b0;
         r_dec_a    <= 4'd0;
         r_dec_le   <= 1'b1;
         r_dec_bi_n <= 1'b0;
         r_dec_lt_n <= 1'b1;
         r_dig_en   <= '0;
      end else if (!enable) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_lz_blank <= 1'b0;
         r_dec_a    <= 4'd0;
         r_dec_le   <= 1'b1;
         r_dec_bi_n <= 1'b0;
         r_dec_lt_n <= 1'b1;
         r_dig_en   <= '0;
      end else begin
         r_dec_lt_n <= ~lt_req;
         case (r_state)
            ST_IDLE: begin
               r_state    <= ST_BLANK;
               r_cnt      <= '0;
               r_dec_a    <= w_rd_data;
               r_dec_le   <= 1'b0;
               r_dec_bi_n <= 1'b0;
               r_dig_en   <= '0;
            end
            ST_BLANK: begin
               if (r_cnt == BLANK_LAST) begin
                  r_state  <= ST_LATCH;
                  r_cnt    <= '0;
                  r_dec_le <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_LATCH: begin
               r_state    <= ST_SHOW;
               r_cnt      <= '0;
               r_lz_blank <= w_blank_lz;
               r_dec_bi_n <= lt_req | ~w_blank_lz;
               r_dig_en   <= w_onehot;
            end
            ST_SHOW: begin
               if (r_cnt == SHOW_LAST) begin
                  r_state    <= ST_BLANK;
                  r_cnt      <= '0;
                  r_idx      <= w_next_idx;
                  r_dec_a    <= w_rd_data;
                  r_dec_le   <= 1'b0;
                  r_dec_bi_n <= 1'b0;
                  r_dig_en   <= '0;
               end else begin
                  r_cnt      <= r_cnt + CW'(1);
                  r_dec_bi_n <= lt_req | ~r_lz_blank;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign dec_a    = r_dec_a;
   assign dec_le   = r_dec_le;
   assign dec_bi_n = r_dec_bi_n;
   assign dec_lt_n = r_dec_lt_n;
   assign dig_en   = r_dig_en;
   assign cur_idx  = r_idx;

endmodule

// File: tb/tb_hc4511_scan_ctrl.sv
// Directed bench for hc4511_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=20, BLANK_CYC=4.
module tb_hc4511_scan_ctrl;
   import hc4511_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n, enable, wr_en, lz_en, lt_req;
   logic [1:0] wr_idx;
   logic [3:0] wr_data;
   logic [3:0] dec_a;
   logic       dec_le, dec_bi_n, dec_lt_n;
   logic [3:0] dig_en;
   logic [1:0] cur_idx;

   int n_run  = 0;
   int n_fail = 0;
   int k      = 0;

   always #5 clk = ~clk;

   hc4511_scan_ctrl #(
      .NUM_DIGITS(4),
      .SCAN_DIV  (20),
      .BLANK_CYC (4)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (enable),
      .wr_en   (wr_en),
      .wr_idx  (wr_idx),
      .wr_data (wr_data),
      .lz_en   (lz_en),
      .lt_req  (lt_req),
      .dec_a   (dec_a),
      .dec_le  (dec_le),
      .dec_bi_n(dec_bi_n),
      .dec_lt_n(dec_lt_n),
      .dig_en  (dig_en),
      .cur_idx (cur_idx)
   );

   typedef struct {
      int          ph;
      logic [15:0] digs;
      logic        lz;
      logic        lt;
      int          k;
      logic [3:0]  dig_en;
      logic [3:0]  a;
      logic        le;
      logic        bi;
      logic        lt_n;
      logic [1:0]  idx;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // One clock, sampled 1 time unit after the edge; also checks the latch/one-hot invariant.
   task automatic tick();
      @(posedge clk);
      #1;
      k++;
      n_run++;
      if ((dig_en != 4'd0 && !dec_le) || (dec_bi_n && !dec_le) || !$onehot0(dig_en)) begin
         n_fail++;
         $display("FAIL invariant k=%0d dig_en=%b dec_le=%b dec_bi_n=%b", k, dig_en, dec_le, dec_bi_n);
      end
   endtask

   task automatic tick_to(input int target);
      while (k < target) tick();
   endtask

   task automatic wr(input logic [1:0] idx, input logic [3:0] data);
      wr_en = 1'b1; wr_idx = idx; wr_data = data;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic [3:0] e_dig, input logic [3:0] e_a,
                          input logic e_le, input logic e_bi, input logic e_lt, input logic [1:0] e_idx);
      chk({tag, " dig_en"},   32'(dig_en),   32'(e_dig));
      chk({tag, " dec_a"},    32'(dec_a),    32'(e_a));
      chk({tag, " dec_le"},   32'(dec_le),   32'(e_le));
      chk({tag, " dec_bi_n"}, 32'(dec_bi_n), 32'(e_bi));
      chk({tag, " dec_lt_n"}, 32'(dec_lt_n), 32'(e_lt));
      chk({tag, " cur_idx"},  32'(cur_idx),  32'(e_idx));
   endtask

   task automatic restart(input logic [15:0] digs, input logic lz, input logic lt);
      enable = 1'b0;
      tick(); tick();
      for (int i = 0; i < 4; i++) wr(2'(i), digs[4*i +: 4]);
      lz_en = lz; lt_req = lt;
      enable = 1'b1;
      k = 0;
   endtask

   function automatic vec_t mk(int ph, logic [15:0] digs, logic lz, logic lt, int kk,
                               logic [3:0] de, logic [3:0] a, logic le, logic bi,
                               logic ltn, logic [1:0] idx);
      vec_t v;
      v.ph = ph; v.digs = digs; v.lz = lz; v.lt = lt; v.k = kk;
      v.dig_en = de; v.a = a; v.le = le; v.bi = bi; v.lt_n = ltn; v.idx = idx;
      return v;
   endfunction

   initial begin
      int          last_ph;
      logic [15:0] d_hi;
      d_hi = {12'h000, BCD_BLANK_MIN + 4'd2};

      // Digits are written as {d3,d2,d1,d0}; slot n occupies edges 1+20n .. 20+20n.
      vt.push_back(mk(0, 16'h1234, 0, 0,  1, 4'b0000, 4, 0, 0, 1, 0));
      vt.push_back(mk(0, 16'h1234, 0, 0,  5, 4'b0000, 4, 1, 0, 1, 0));
      vt.push_back(mk(0, 16'h1234, 0, 0,  6, 4'b0001, 4, 1, 1, 1, 0));
      vt.push_back(mk(0, 16'h1234, 0, 0, 20, 4'b0001, 4, 1, 1, 1, 0));
      vt.push_back(mk(0, 16'h1234, 0, 0, 21, 4'b0000, 3, 0, 0, 1, 1));
      vt.push_back(mk(0, 16'h1234, 0, 0, 26, 4'b0010, 3, 1, 1, 1, 1));
      vt.push_back(mk(0, 16'h1234, 0, 0, 40, 4'b0010, 3, 1, 1, 1, 1));
      vt.push_back(mk(0, 16'h1234, 0, 0, 41, 4'b0000, 2, 0, 0, 1, 2));
      vt.push_back(mk(0, 16'h1234, 0, 0, 46, 4'b0100, 2, 1, 1, 1, 2));
      vt.push_back(mk(0, 16'h1234, 0, 0, 66, 4'b1000, 1, 1, 1, 1, 3));
      vt.push_back(mk(0, 16'h1234, 0, 0, 80, 4'b1000, 1, 1, 1, 1, 3));
      vt.push_back(mk(0, 16'h1234, 0, 0, 81, 4'b0000, 4, 0, 0, 1, 0));
      vt.push_back(mk(0, 16'h1234, 0, 0, 86, 4'b0001, 4, 1, 1, 1, 0));
      vt.push_back(mk(1, 16'h0070, 1, 0,  6, 4'b0001, 0, 1, 1, 1, 0));
      vt.push_back(mk(1, 16'h0070, 1, 0, 26, 4'b0010, 7, 1, 1, 1, 1));
      vt.push_back(mk(1, 16'h0070, 1, 0, 45, 4'b0000, 0, 1, 0, 1, 2));
      vt.push_back(mk(1, 16'h0070, 1, 0, 46, 4'b0100, 0, 1, 0, 1, 2));
      vt.push_back(mk(1, 16'h0070, 1, 0, 66, 4'b1000, 0, 1, 0, 1, 3));
      vt.push_back(mk(2, 16'h0000, 1, 0,  6, 4'b0001, 0, 1, 1, 1, 0));
      vt.push_back(mk(2, 16'h0000, 1, 0, 26, 4'b0010, 0, 1, 0, 1, 1));
      vt.push_back(mk(2, 16'h0000, 1, 0, 46, 4'b0100, 0, 1, 0, 1, 2));
      vt.push_back(mk(2, 16'h0000, 1, 0, 66, 4'b1000, 0, 1, 0, 1, 3));
      vt.push_back(mk(3, 16'h0000, 0, 0, 26, 4'b0010, 0, 1, 1, 1, 1));
      vt.push_back(mk(3, 16'h0000, 0, 0, 66, 4'b1000, 0, 1, 1, 1, 3));
      vt.push_back(mk(4, 16'h0000, 1, 1,  1, 4'b0000, 0, 0, 0, 0, 0));
      vt.push_back(mk(4, 16'h0000, 1, 1, 21, 4'b0000, 0, 0, 0, 0, 1));
      vt.push_back(mk(4, 16'h0000, 1, 1, 26, 4'b0010, 0, 1, 1, 0, 1));
      vt.push_back(mk(4, 16'h0000, 1, 1, 66, 4'b1000, 0, 1, 1, 0, 3));
      vt.push_back(mk(5, d_hi,     0, 0,  6, 4'b0001, d_hi[3:0], 1, 1, 1, 0));

      rst_n = 1'b0; enable = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_data = '0;
      lz_en = 1'b0; lt_req = 1'b0;
      #12;
      chk_out("reset", 4'b0000, 0, 1, 0, 1, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      last_ph = -1;
      foreach (vt[i]) begin
         if (vt[i].ph != last_ph) begin
            restart(vt[i].digs, vt[i].lz, vt[i].lt);
            last_ph = vt[i].ph;
         end
         tick_to(vt[i].k);
         chk_out($sformatf("vec ph%0d k%0d", vt[i].ph, vt[i].k), vt[i].dig_en, vt[i].a,
                 vt[i].le, vt[i].bi, vt[i].lt_n, vt[i].idx);
      end

      // Lamp test raised and dropped inside a leading-zero-blanked slot.
      restart(16'h0000, 1, 0);
      tick_to(50);
      chk_out("lt before", 4'b0100, 0, 1, 0, 1, 2);
      lt_req = 1'b1;
      tick();
      chk_out("lt on", 4'b0100, 0, 1, 1, 0, 2);
      tick_to(55);
      lt_req = 1'b0;
      tick();
      chk_out("lt off", 4'b0100, 0, 1, 0, 1, 2);

      // Writes to the shown digit and on the BLANK-entry edge are deferred a visit.
      restart(16'h1234, 0, 0);
      tick_to(10);
      wr(2'd0, 4'd5);
      chk("wr shown dec_a", 32'(dec_a), 32'd4);
      tick_to(20);
      wr(2'd1, 4'd9);
      chk("wr blank-entry dec_a", 32'(dec_a), 32'd3);
      chk("wr blank-entry idx", 32'(cur_idx), 32'd1);
      tick_to(26);
      chk("wr same slot dec_a", 32'(dec_a), 32'd3);
      tick_to(81);
      chk("wr d0 next visit", 32'(dec_a), 32'd5);
      tick_to(101);
      chk("wr d1 next visit", 32'(dec_a), 32'd9);

      // Disable mid-SHOW, then restart from digit 0.
      restart(16'h1234, 0, 0);
      tick_to(30);
      chk("pre-disable dig_en", 32'(dig_en), 32'h2);
      enable = 1'b0;
      tick();
      chk_out("disabled", 4'b0000, 0, 1, 0, 1, 0);
      enable = 1'b1;
      k = 0;
      tick();
      chk_out("reenable blank", 4'b0000, 4, 0, 0, 1, 0);
      tick_to(6);
      chk_out("reenable show", 4'b0001, 4, 1, 1, 1, 0);

      // Asynchronous reset during LATCH.
      restart(16'h1234, 0, 0);
      tick_to(5);
      chk("latch le", 32'(dec_le), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_out("async reset", 4'b0000, 0, 1, 0, 1, 0);
      tick();
      rst_n = 1'b1;
      k = 0;
      tick();
      chk_out("post-reset blank", 4'b0000, 0, 0, 0, 1, 0);
      tick_to(26);
      chk_out("post-reset d1", 4'b0010, 0, 1, 1, 1, 1);
      tick_to(46);
      chk_out("post-reset d2", 4'b0100, 0, 1, 1, 1, 2);
      tick_to(66);
      chk_out("post-reset d3", 4'b1000, 0, 1, 1, 1, 3);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
